icache_refill: RTL and testbench

- Instruction-cache refill engine directly upstream of the IF stage.
- On a miss reported by IF, it fetches one aligned cache line from memory over an AXI4-Lite read channel, one word per transaction.
- Each returned word is written into the I-cache data array; the tag is written on success.
- A one-cycle refill_complete pulse releases IF from its miss stall.

---
 rtl/icache_refill.sv | 185 ++++++++++++++++++
 tb/tb_icache_refill.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
//
// Instruction-cache line refill engine sitting directly upstream of the IF
// stage. When IF reports a miss, the engine reads one aligned cache line from
// memory over an AXI4-Lite read channel, one word per AXI transaction. Each
// returned word is written straight into the I-cache data array. The
// tag/valid entry is written only if every beat came back OKAY. A one-cycle
// refill_complete pulse then releases IF from its miss stall.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   cache_miss_detected    miss request from IF (level, sampled in IDLE)
//   miss_addr              faulting fetch address
//   busy                   high whenever the engine is not idle
//   ARADDR/ARVALID/ARREADY AXI4-Lite read address channel
//   RDATA/RRESP/RVALID/RREADY AXI4-Lite read data channel
//   line_we/line_index/line_word_idx/line_wdata  data-array write port
//   tag_we/tag_value       tag/valid write port (line_index selects the set)
//   refill_complete        one-cycle pulse when the refill finishes
//   refill_error           one-cycle pulse (with refill_complete) when any
//                          beat returned a non-OKAY response
// ---------------------------------------------------------------------------
module icache_refill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cache_miss_detected,
  input  logic [ADDR_W-1:0]                           miss_addr,
  output logic                                        busy,
  output logic [ADDR_W-1:0]                           ARADDR,
  output logic                                        ARVALID,
  input  logic                                        ARREADY,
  input  logic [DATA_W-1:0]                           RDATA,
  input  logic [1:0]                                  RRESP,
  input  logic                                        RVALID,
  output logic                                        RREADY,
  output logic                                        line_we,
  output logic [INDEX_BITS-1:0]                       line_index,
  output logic [$clog2(LINE_WORDS)-1:0]               line_word_idx,
  output logic [DATA_W-1:0]                           line_wdata,
  output logic                                        tag_we,
  output logic [ADDR_W-INDEX_BITS-$clog2(LINE_WORDS)-$clog2(DATA_W/8)-1:0] tag_value,
  output logic                                        refill_complete,
  output logic                                        refill_error
);

  // Address field geometry.
  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int BYTE_OFF  = $clog2(DATA_W / 8);
  localparam int OFF       = WORD_BITS + BYTE_OFF;

  // Mask of the in-line offset bits; clearing them gives the line base.
  localparam logic [ADDR_W-1:0]    OFF_MASK  = (ADDR_W'(1) << OFF) - ADDR_W'(1);
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                 state_reg;
  logic [ADDR_W-1:0]      base_reg;
  logic [WORD_BITS-1:0]   cnt_reg;
  logic                   err_reg;

  // Registered outputs.
  logic [ADDR_W-1:0]      araddr_reg;
  logic                   arvalid_reg;
  logic                   rready_reg;
  logic                   busy_reg;
  logic                   tag_we_reg;
  logic                   complete_reg;
  logic                   error_reg;

  logic [WORD_BITS-1:0]   cnt_next;
  logic                   beat_err;
  logic                   r_fire;

  assign cnt_next = cnt_reg + WORD_BITS'(1);
  assign beat_err = (RRESP != 2'b00);

  // rready_reg is only ever high in DATA, so this is the R handshake.
  assign r_fire = rready_reg & RVALID;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      base_reg     <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      araddr_reg   <= '0;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      tag_we_reg   <= 1'b0;
      complete_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      // DONE-cycle pulses default low; they are set only on entry to DONE.
      tag_we_reg   <= 1'b0;
      complete_reg <= 1'b0;
      error_reg    <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (cache_miss_detected) begin
            base_reg    <= miss_addr & ~OFF_MASK;
            araddr_reg  <= miss_addr & ~OFF_MASK;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            arvalid_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= S_ADDR;
          end
        end

        S_ADDR: begin
          // ARVALID and ARADDR are held until the slave accepts.
          if (ARREADY) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= S_DATA;
          end
        end

        S_DATA: begin
          if (RVALID) begin
            rready_reg <= 1'b0;
            if (beat_err) begin
              err_reg <= 1'b1;
            end
            if (cnt_reg == LAST_WORD) begin
              // Fold in the current beat's response so the final
              // word's error is not missed by the DONE pulses.
              complete_reg <= 1'b1;
              tag_we_reg   <= ~(err_reg | beat_err);
              error_reg    <= err_reg | beat_err;
              state_reg    <= S_DONE;
            end else begin
              // base_reg is line aligned, so OR-ing in the word offset
              // equals addition and can never carry past the line.
              cnt_reg     <= cnt_next;
              araddr_reg  <= base_reg | (ADDR_W'(cnt_next) << BYTE_OFF);
              arvalid_reg <= 1'b1;
              state_reg   <= S_ADDR;
            end
          end
        end

        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_reg;
  assign ARADDR          = araddr_reg;
  assign ARVALID         = arvalid_reg;
  assign RREADY          = rready_reg;
  assign tag_we          = tag_we_reg;
  assign refill_complete = complete_reg;
  assign refill_error    = error_reg;

  // The data-array write happens in the same cycle as the R handshake.
  assign line_we         = r_fire;
  assign line_word_idx   = cnt_reg;
  assign line_wdata      = RDATA;

  assign line_index      = base_reg[OFF+INDEX_BITS-1:OFF];
  assign tag_value       = base_reg[ADDR_W-1:OFF+INDEX_BITS];

endmodule

// File: tb/tb_icache_refill.sv
// ---------------------------------------------------------------------------
// tb_icache_refill
//
// Self-checking bench for icache_refill with default parameters
// (32-bit address and data, 4-word lines, 6 index bits).
//
// The bench acts as the AXI4-Lite slave. The expected bus addresses, data
// writes, tag fields, error flag and latency for each refill are computed
// from the line geometry with plain arithmetic. The bench then walks the
// refill cycle by cycle and compares.
// ---------------------------------------------------------------------------
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_miss_detected;
  logic [31:0] miss_addr;
  logic        busy;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        line_we;
  logic [5:0]  line_index;
  logic [1:0]  line_word_idx;
  logic [31:0] line_wdata;
  logic        tag_we;
  logic [21:0] tag_value;
  logic        refill_complete;
  logic        refill_error;

  icache_refill dut (
    .clk                 (clk),
    .rst                 (rst),
    .cache_miss_detected (cache_miss_detected),
    .miss_addr           (miss_addr),
    .busy                (busy),
    .ARADDR              (ARADDR),
    .ARVALID             (ARVALID),
    .ARREADY             (ARREADY),
    .RDATA               (RDATA),
    .RRESP               (RRESP),
    .RVALID              (RVALID),
    .RREADY              (RREADY),
    .line_we             (line_we),
    .line_index          (line_index),
    .line_word_idx       (line_word_idx),
    .line_wdata          (line_wdata),
    .tag_we              (tag_we),
    .tag_value           (tag_value),
    .refill_complete     (refill_complete),
    .refill_error        (refill_error)
  );

  always #5 clk = ~clk;

  int vec_count   = 0;
  int miscompares = 0;

  // Per-refill slave behaviour: stall cycles before AR/R handshakes,
  // response codes and data returned for each word.
  logic [31:0] data_cfg [4];
  logic [1:0]  resp_cfg [4];
  int          ar_stall [4];
  int          r_stall  [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 4; i++) begin
      data_cfg[i] = 32'hA0 + 32'(i);
      resp_cfg[i] = 2'd0;
      ar_stall[i] = 0;
      r_stall[i]  = 0;
    end
  endtask

  // Runs one refill from an idle engine.
  //   abort_word >= 0 : pulse rst instead of returning that word.
  //   hold = 1        : keep the miss request high throughout and switch
  //                     miss_addr to next_addr mid-refill.
  task automatic refill(input logic [31:0] addr, input int abort_word,
                        input bit hold, input logic [31:0] next_addr);
    logic [31:0] base;
    logic [31:0] exp_addr;
    bit          exp_err;
    int          exp_lat;
    int          cycles;
    int          w;
    int          ar_wait;
    int          r_wait;
    bit          done;

    base    = addr & 32'hFFFF_FFF0;
    exp_err = 1'b0;
    exp_lat = 10;  // accept cycle through DONE cycle, inclusive
    for (int i = 0; i < 4; i++) begin
      if (resp_cfg[i] != 2'd0) exp_err = 1'b1;
      exp_lat += ar_stall[i] + r_stall[i];
    end

    // Accept cycle: the engine must be idle with no leftover pulse.
    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_complete", refill_complete, 0);
    cache_miss_detected = 1'b1;
    miss_addr = addr;
    ARREADY = 1'b0;
    RVALID  = 1'b0;

    cycles  = 1;
    w       = 0;
    ar_wait = 0;
    r_wait  = 0;
    done    = 1'b0;

    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (!hold) begin
        cache_miss_detected = 1'b0;
        miss_addr = $urandom;
      end else if (w == 2) begin
        miss_addr = next_addr;
      end
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RDATA   = $urandom;
      RRESP   = 2'($urandom_range(0, 3));

      if (ARVALID) begin
        exp_addr = base + 32'(w * 4);
        check_eq("araddr", ARADDR, exp_addr);
        if (w < 4 && ar_wait < ar_stall[w]) begin
          ar_wait++;
        end else begin
          ARREADY = 1'b1;
          ar_wait = 0;
        end
      end else if (RREADY) begin
        if (abort_word == w) begin
          rst = 1'b1;
          @(negedge clk);
          check_eq("abort_arvalid", ARVALID, 0);
          check_eq("abort_rready", RREADY, 0);
          check_eq("abort_busy", busy, 0);
          check_eq("abort_complete", refill_complete, 0);
          check_eq("abort_tag_we", tag_we, 0);
          check_eq("abort_araddr", ARADDR, 0);
          rst = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_abort_complete", refill_complete, 0);
            check_eq("post_abort_tag_we", tag_we, 0);
            check_eq("post_abort_busy", busy, 0);
          end
          $display("refill base=%08h aborted by reset at word %0d", base, w);
          return;
        end
        if (w < 4 && r_wait < r_stall[w]) begin
          r_wait++;
        end else begin
          RVALID = 1'b1;
          RDATA  = data_cfg[w];
          RRESP  = resp_cfg[w];
        end
      end

      #1;
      check_eq("ar_r_exclusive", ARVALID & RREADY, 0);
      check_eq("line_we", line_we, RVALID);
      if (RVALID) begin
        check_eq("word_idx", line_word_idx, w);
        check_eq("wdata", line_wdata, data_cfg[w]);
        w++;
        r_wait = 0;
      end

      if (refill_complete) begin
        check_eq("done_words", w, 4);
        check_eq("done_latency", cycles, exp_lat);
        check_eq("done_tag_we", tag_we, !exp_err);
        check_eq("done_error", refill_error, exp_err);
        check_eq("done_index", line_index, (base >> 4) & 32'h3F);
        check_eq("done_tag", tag_value, base >> 10);
        check_eq("done_busy", busy, 1);
        $display("refill base=%08h idx=%02h tag=%06h resp_err=%0d cycles=%0d",
                 base, line_index, tag_value, refill_error, cycles);
        done = 1'b1;
      end else begin
        check_eq("busy", busy, 1);
        check_eq("tag_we_quiet", tag_we, 0);
        check_eq("error_quiet", refill_error, 0);
      end
    end

    if (!done) begin
      check_eq("timeout", 0, 1);
    end
    ARREADY = 1'b0;
    RVALID  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cache_miss_detected = 1'b0;
    miss_addr = 32'h0;
    ARREADY = 1'b0;
    RDATA   = 32'h0;
    RRESP   = 2'd0;
    RVALID  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_arvalid", ARVALID, 0);
    check_eq("rst_rready", RREADY, 0);
    check_eq("rst_line_we", line_we, 0);
    check_eq("rst_tag_we", tag_we, 0);
    check_eq("rst_complete", refill_complete, 0);
    check_eq("rst_error", refill_error, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_araddr", ARADDR, 0);
    check_eq("rst_word_idx", line_word_idx, 0);
    rst = 1'b0;

    // Basic refill.
    clear_cfg();
    refill(32'h0000_1234, -1, 1'b0, 32'h0);

    // Address backpressure on the second word.
    clear_cfg();
    ar_stall[1] = 3;
    refill(32'h0000_1234, -1, 1'b0, 32'h0);

    // Error response on word 1.
    clear_cfg();
    resp_cfg[1] = 2'd2;
    refill(32'h0000_1234, -1, 1'b0, 32'h0);

    // Reset while waiting for word 2, then a refill at the top of memory.
    clear_cfg();
    refill(32'h0000_5678, 2, 1'b0, 32'h0);
    clear_cfg();
    refill(32'hFFFF_FFF8, -1, 1'b0, 32'h0);

    // Back-to-back misses: the request stays high across DONE.
    clear_cfg();
    refill(32'h0000_2000, -1, 1'b1, 32'h0000_3344);
    for (int i = 0; i < 4; i++) data_cfg[i] = 32'hB0 + 32'(i);
    refill(32'h0000_3344, -1, 1'b0, 32'h0);

    // Randomized refills.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) begin
        data_cfg[i] = $urandom;
        resp_cfg[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        ar_stall[i] = $urandom_range(0, 2);
        r_stall[i]  = $urandom_range(0, 2);
      end
      refill($urandom, -1, 1'b0, 32'h0);
    end

    @(negedge clk);
    check_eq("final_busy", busy, 0);
    check_eq("final_complete", refill_complete, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
